mem_stage_mc: RTL

//  Next-generation MEM stage: sits between the EX/MEM and MEM/WB boundaries of the pipeline.

---
 rtl/mem_stage_mc.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_mc.sv
// mem_stage_mc: pipeline MEM stage with a variable-latency data memory interface.
//
// Picks the load address (pipeline or forwarded) and sends a word-aligned request over
// valid/ready. It holds the upstream stage until the response returns. It then extracts
// the byte, half or word lane (little-endian) with zero or sign extension and registers
// the result, the rd fields and the flags into the MEM/WB slot.
//
// Optional feature: define MEM_MISALIGN_CHECK_EN to trap misaligned half/word loads.
// A trapped load is not sent to memory. It completes in one cycle with p4_misalign=1
// and p4_mem_out=0.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   p3_*                       EX/MEM slot: valid, load control, rd fields, aluOut, address, flags
//   f_mem_address_sel/_address forwarded load address and its select
//   stall_out                  upstream must hold p3_* stable
//   mem_req_valid/ready/addr   memory request channel (word-aligned address)
//   mem_rsp_valid/data         memory response channel
//   p4_*                       MEM/WB slot: valid, rd fields, aluOut, load data, flags, misalign
module mem_stage_mc #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p3_valid,
  input  logic              p3_is_load,
  input  logic [1:0]        p3_ld_size,
  input  logic              p3_ld_signed,
  input  logic [RD_W-1:0]   p3_alu_rd,
  input  logic [RD_W-1:0]   p3_mem_rd,
  input  logic [DATA_W-1:0] p3_alu_aluOut,
  input  logic [ADDR_W-1:0] p3_mem_address,
  input  logic              f_mem_address_sel,
  input  logic [ADDR_W-1:0] f_mem_address,
  input  logic              p3_flag_z,
  input  logic              p3_flag_n,
  input  logic              p3_flag_c,
  input  logic              p3_flag_v,
  output logic              stall_out,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              p4_valid,
  output logic [RD_W-1:0]   p4_alu_rd,
  output logic [RD_W-1:0]   p4_mem_rd,
  output logic [DATA_W-1:0] p4_alu_aluOut,
  output logic [DATA_W-1:0] p4_mem_out,
  output logic              p4_flag_z,
  output logic              p4_flag_n,
  output logic              p4_flag_c,
  output logic              p4_flag_v,
  output logic              p4_misalign
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);

  typedef enum logic [0:0] {StIdle, StWaitRsp} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_sel;
  logic [OFF_W-1:0]  lane_off;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] lane_shifted;
  logic              lane_sign;
  logic [DATA_W-1:0] lane_ext;

  // Capture controls for the MEM/WB slot.
  logic              cap;
  logic              cap_valid;
  logic [DATA_W-1:0] cap_mem_out;
  logic              cap_misalign;

  logic              p4_valid_q;
  logic [RD_W-1:0]   p4_alu_rd_q, p4_mem_rd_q;
  logic [DATA_W-1:0] p4_alu_aluOut_q, p4_mem_out_q;
  logic [3:0]        p4_flags_q;
  logic              p4_misalign_q;

  assign addr_sel     = f_mem_address_sel ? f_mem_address : p3_mem_address;
  assign mem_req_addr = {addr_sel[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Lane extraction: shift the selected lane down to bit 0, then mask and extend.
  // Size 3 decodes as word.
  always_comb begin
    lane_off  = addr_sel[OFF_W-1:0];
    lane_mask = DATA_W'(32'hFFFF_FFFF);
    case (p3_ld_size)
      2'd0: begin
        lane_off  = addr_sel[OFF_W-1:0];
        lane_mask = DATA_W'(16'h00FF);
      end
      2'd1: begin
        lane_off  = addr_sel[OFF_W-1:0] & ~OFF_W'(1);
        lane_mask = DATA_W'(16'hFFFF);
      end
      default: begin
        lane_off  = addr_sel[OFF_W-1:0] & ~OFF_W'(3);
        lane_mask = DATA_W'(32'hFFFF_FFFF);
      end
    endcase
    lane_shifted = mem_rsp_data >> {lane_off, 3'b000};
    case (p3_ld_size)
      2'd0:    lane_sign = lane_shifted[7];
      2'd1:    lane_sign = lane_shifted[15];
      default: lane_sign = lane_shifted[31];
    endcase
    lane_ext = (lane_shifted & lane_mask) | ((p3_ld_signed && lane_sign) ? ~lane_mask : '0);
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    case (p3_ld_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr_sel[0];
      default: misaligned = (addr_sel[1:0] != 2'b00);
    endcase
  end
`endif

  always_comb begin
    state_d       = state_q;
    stall_out     = 1'b0;
    mem_req_valid = 1'b0;
    cap           = 1'b0;
    cap_valid     = 1'b0;
    cap_mem_out   = '0;
    cap_misalign  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (p3_valid && p3_is_load) begin
`ifdef MEM_MISALIGN_CHECK_EN
          if (misaligned) begin
            cap          = 1'b1;
            cap_valid    = 1'b1;
            cap_misalign = 1'b1;
          end else begin
            mem_req_valid = 1'b1;
            stall_out     = 1'b1;
            if (mem_req_ready) state_d = StWaitRsp;
          end
`else
          mem_req_valid = 1'b1;
          stall_out     = 1'b1;
          if (mem_req_ready) state_d = StWaitRsp;
`endif
        end else begin
          // Non-loads and empty slots pass straight through.
          cap       = 1'b1;
          cap_valid = p3_valid;
        end
      end
      StWaitRsp: begin
        stall_out = 1'b1;
        if (mem_rsp_valid) begin
          stall_out   = 1'b0;
          cap         = 1'b1;
          cap_valid   = 1'b1;
          cap_mem_out = lane_ext;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      p4_valid_q      <= 1'b0;
      p4_alu_rd_q     <= '0;
      p4_mem_rd_q     <= '0;
      p4_alu_aluOut_q <= '0;
      p4_mem_out_q    <= '0;
      p4_flags_q      <= '0;
      p4_misalign_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      // A stalled cycle produces a bubble; the data fields keep their last values.
      p4_valid_q <= cap & cap_valid;
      if (cap) begin
        p4_alu_rd_q     <= p3_alu_rd;
        p4_mem_rd_q     <= p3_mem_rd;
        p4_alu_aluOut_q <= p3_alu_aluOut;
        p4_mem_out_q    <= cap_mem_out;
        p4_flags_q      <= {p3_flag_z, p3_flag_n, p3_flag_c, p3_flag_v};
        p4_misalign_q   <= cap_misalign;
      end
    end
  end

  assign p4_valid      = p4_valid_q;
  assign p4_alu_rd     = p4_alu_rd_q;
  assign p4_mem_rd     = p4_mem_rd_q;
  assign p4_alu_aluOut = p4_alu_aluOut_q;
  assign p4_mem_out    = p4_mem_out_q;
  assign p4_flag_z     = p4_flags_q[3];
  assign p4_flag_n     = p4_flags_q[2];
  assign p4_flag_c     = p4_flags_q[1];
  assign p4_flag_v     = p4_flags_q[0];
  assign p4_misalign   = p4_misalign_q;

endmodule
